cnt_seg_scan: RTL and testbench
===============================

CNT_SEG_SCAN -- requirements
Module: cnt_seg_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4, which sets the clock cycles each digit is driven (legal range ≥1).
REQ-002 The block SHALL have parameter BLANK_CYC, default 1, which sets the all-off cycles after each digit (legal range ≥1).
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cnt_in, input, 4 bits: the count value from the upstream mod counter, range 0-15.
REQ-006 The block SHALL have port cnt_vld, input, 1 bit: when high, cnt_in is valid this cycle.
REQ-007 The block SHALL have port seg, output, 8 bits: active-low segments, where bit7 = dp and bits6..0 = g..a.
REQ-008 The block SHALL have port sel, output, 2 bits: active-low digit select, where bit0 = units and bit1 = tens.
REQ-009 The block SHALL have port wrap_pulse, output, 1 bit: a one-cycle pulse when the upstream count wraps.

Function
REQ-010 The block SHALL hold a sample register, samp[3:0], which loads cnt_in on every cycle in which cnt_vld=1 and otherwise holds its value.
REQ-011 The block SHALL hold a frame register, frame[3:0], which loads samp (its pre-edge value) only on the transition S_BLANK1->S_DIG0; the displayed value SHALL never change mid-frame.
REQ-012 For digit extraction, units SHALL equal frame mod 10 and tens SHALL equal frame/10 (0 or 1), both derived combinationally from frame.
REQ-013 The state machine SHALL have exactly four states, S_DIG0, S_BLANK0, S_DIG1 and S_BLANK1, and a dwell timer.
REQ-014 S_DIG0 and S_DIG1 SHALL each last SCAN_DIV cycles, and S_BLANK0 and S_BLANK1 SHALL each last BLANK_CYC cycles.
REQ-015 State transitions SHALL follow the fixed cyclic order S_DIG0->S_BLANK0->S_DIG1->S_BLANK1->S_DIG0; there SHALL be no other transitions.
REQ-016 A frame SHALL last 2*(SCAN_DIV+BLANK_CYC) cycles, which is 10 cycles at the default parameters.
REQ-017 The dwell timer SHALL clear on every state change, and the timer width SHALL cover max(SCAN_DIV,BLANK_CYC)-1 without overflow.
REQ-018 seg and sel SHALL be registered outputs that are a pure function of the registered state and frame, with no combinational path from cnt_in or cnt_vld.
REQ-019 In S_DIG0, the outputs SHALL be sel=2'b10 and seg=code(units).
REQ-020 In S_DIG1 with tens=1, the outputs SHALL be sel=2'b01 and seg=code(1).
REQ-021 In S_DIG1 with tens=0, the outputs SHALL be sel=2'b01 and seg=8'hFF (leading-zero blanking).
REQ-022 In S_BLANK0 and S_BLANK1, the outputs SHALL be sel=2'b11 and seg=8'hFF.
REQ-023 The segment code table SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (all hex), and dp SHALL always be 1 (off).
REQ-024 seg and sel SHALL change on the same edge as the state, so they are never driven active at the same time as the wrong digit.
REQ-025 wrap_pulse SHALL be 1 for exactly the one cycle after an edge where cnt_vld=1 and cnt_in<samp (for example 15->0), and SHALL be 0 otherwise.
REQ-026 If cnt_vld=1 on the frame-load edge, frame SHALL take the old samp and the new value SHALL appear on the next frame.
REQ-027 A repeated equal value, or an increase in value, SHALL NOT assert wrap_pulse.
REQ-028 If cnt_vld is held low, samp, frame and the display SHALL hold indefinitely.

Reset
REQ-029 When sys_rst_n=0, the block SHALL immediately (asynchronously) force: state=S_BLANK1, timer=0, samp=0, frame=0, seg=8'hFF, sel=2'b11, wrap_pulse=0.
REQ-030 Reset SHALL be honoured in any state, including mid-frame, and no partial digit SHALL be driven after sys_rst_n falls.
REQ-031 After reset is released, the first S_DIG0 SHALL begin after BLANK_CYC edges, and the block SHALL then display 0 (sel=10, seg=C0, tens blanked).

Verification
REQ-032 Reset scenario: hold sys_rst_n=0 for 20 ns and then release -> seg=FF and sel=11 during reset; after 1 cycle sel=10 and seg=C0; the sequence repeats with a 10-cycle period.
REQ-033 Two-digit scenario: drive cnt_in=12 with cnt_vld=1 for one cycle -> the next frame shows sel=10/seg=A4 for 4 cycles, then 11/FF for 1 cycle, then 01/F9 for 4 cycles, then 11/FF for 1 cycle.
REQ-034 Wrap scenario: step cnt_in 14, 15, 0 with cnt_vld=1 each cycle -> wrap_pulse=1 for exactly one cycle, following the 15->0 edge only.
REQ-035 Frame-stability scenario: change cnt_in from 3 to 7 mid-frame (during S_DIG1) -> the units digit stays B0 until the next S_DIG0, then shows F8.
REQ-036 Reset mid-frame scenario: assert sys_rst_n=0 while in S_DIG0 showing 9 -> seg=FF and sel=11 immediately; after release the display shows 0.
REQ-037 Parameter scenario: run with SCAN_DIV=1 and BLANK_CYC=2 -> the frame lasts 6 cycles and sel is never 2'b00 in any cycle.

Source files
------------

// File: rtl/cnt_seg_scan.sv
// Two-digit multiplexed 7-segment driver for a 0-15 count.
// Scans units then tens, with blanking gaps between digits and a latched per-frame value.
module cnt_seg_scan #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] cnt_in,
  input  logic       cnt_vld,
  output logic [7:0] seg,
  output logic [1:0] sel,
  output logic       wrap_pulse
);

  localparam int unsigned MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] DIG_LAST   = TMR_W'(SCAN_DIV - 1);
  localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    S_DIG0   = 2'd0,
    S_BLANK0 = 2'd1,
    S_DIG1   = 2'd2,
    S_BLANK1 = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       samp_q, samp_d;
  logic [3:0]       frame_q, frame_d;
  logic [7:0]       seg_q, seg_d;
  logic [1:0]       sel_q, sel_d;
  logic             wrap_q, wrap_d;
  logic [3:0]       units_d;
  logic             tens_d;

  // Active-low segment pattern for a decimal digit, dp always off
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Next state, sample/frame capture, and outputs for the upcoming state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TMR_W'(1);
    samp_d  = samp_q;
    frame_d = frame_q;
    wrap_d  = 1'b0;
    seg_d   = 8'hFF;
    sel_d   = 2'b11;

    if (cnt_vld) begin
      samp_d = cnt_in;
      wrap_d = (cnt_in < samp_q);
    end

    case (state_q)
      S_DIG0: if (timer_q == DIG_LAST) begin
        state_d = S_BLANK0;
        timer_d = '0;
      end
      S_BLANK0: if (timer_q == BLANK_LAST) begin
        state_d = S_DIG1;
        timer_d = '0;
      end
      S_DIG1: if (timer_q == DIG_LAST) begin
        state_d = S_BLANK1;
        timer_d = '0;
      end
      S_BLANK1: if (timer_q == BLANK_LAST) begin
        state_d = S_DIG0;
        timer_d = '0;
        frame_d = samp_q;
      end
      default: begin
        state_d = S_BLANK1;
        timer_d = '0;
      end
    endcase

    tens_d  = (frame_d >= 4'd10);
    units_d = tens_d ? (frame_d - 4'd10) : frame_d;

    // Outputs track the state being entered so digit and select switch together
    case (state_d)
      S_DIG0: begin
        sel_d = 2'b10;
        seg_d = seg_code(units_d);
      end
      S_DIG1: begin
        sel_d = 2'b01;
        seg_d = tens_d ? seg_code(4'd1) : 8'hFF;
      end
      default: begin
        sel_d = 2'b11;
        seg_d = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_BLANK1;
      timer_q <= '0;
      samp_q  <= '0;
      frame_q <= '0;
      seg_q   <= 8'hFF;
      sel_q   <= 2'b11;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      samp_q  <= samp_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_cnt_seg_scan.sv
// Bench for cnt_seg_scan: default instance plus a SCAN_DIV=1/BLANK_CYC=2 instance,
// checked every cycle against a frame-position model and at hand-computed points.
module tb_cnt_seg_scan;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cin   = 4'd0;
  logic       vld   = 1'b0;
  logic [7:0] seg0, seg1;
  logic [1:0] sel0, sel1;
  logic       wrap0, wrap1;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  localparam logic [7:0] CODE_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  cnt_seg_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .cnt_in(cin), .cnt_vld(vld),
    .seg(seg0), .sel(sel0), .wrap_pulse(wrap0)
  );

  cnt_seg_scan #(.SCAN_DIV(1), .BLANK_CYC(2)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .cnt_in(cin), .cnt_vld(vld),
    .seg(seg1), .sel(sel1), .wrap_pulse(wrap1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // n = edges since reset release; position within the repeating frame decides the digit
  function automatic int frame_pos(input int n, input int sd, input int bc);
    if (n < bc) return -1;
    return (n - bc) % (2 * (sd + bc));
  endfunction

  function automatic logic [1:0] exp_sel(input int n, input int sd, input int bc);
    int p;
    p = frame_pos(n, sd, bc);
    if (p < 0)             return 2'b11;
    if (p < sd)            return 2'b10;
    if (p < sd + bc)       return 2'b11;
    if (p < 2 * sd + bc)   return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [7:0] exp_seg(input int n, input int sd, input int bc, input int fr);
    int p;
    p = frame_pos(n, sd, bc);
    if (p < 0) return 8'hFF;
    if (p < sd) return CODE_TBL[fr % 10];
    if (p < sd + bc) return 8'hFF;
    if (p < 2 * sd + bc) return (fr >= 10) ? CODE_TBL[1] : 8'hFF;
    return 8'hFF;
  endfunction

  function automatic bit is_load(input int n, input int sd, input int bc);
    return (n >= bc) && (((n - bc) % (2 * (sd + bc))) == 0);
  endfunction

  // Reference model state
  int   n0 = 0, n1 = 0, msamp = 0, mfr0 = 0, mfr1 = 0;
  logic mwrap = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n0 <= 0; n1 <= 0; msamp <= 0; mfr0 <= 0; mfr1 <= 0; mwrap <= 1'b0;
    end else begin
      n0 <= n0 + 1;
      n1 <= n1 + 1;
      if (is_load(n0 + 1, 4, 1)) mfr0 <= msamp;
      if (is_load(n1 + 1, 1, 2)) mfr1 <= msamp;
      if (vld) msamp <= int'(cin);
      mwrap <= vld && (int'(cin) < msamp);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("seg0", seg0, exp_seg(n0, 4, 1, mfr0));
    chk("sel0", 8'(sel0), 8'(exp_sel(n0, 4, 1)));
    chk("wrap0", 8'(wrap0), 8'(mwrap));
    chk("seg1", seg1, exp_seg(n1, 1, 2, mfr1));
    chk("sel1", 8'(sel1), 8'(exp_sel(n1, 1, 2)));
    chk("wrap1", 8'(wrap1), 8'(mwrap));
    chk("sel1_not_both", 8'(sel1 == 2'b00), 8'd0);
  end

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  logic [1:0] two_sel [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
  logic [7:0] two_seg [10] = '{8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hFF,
                               8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hFF};
  logic [3:0] vals [4]     = '{4'd15, 4'd10, 4'd8, 4'd5};

  initial begin
    #22 rst_n = 1'b1;
    cyc = 0;
    go_to(1);
    chk("rst_sel0", 8'(sel0), 8'(2'b10));
    chk("rst_seg0", seg0, 8'hC0);
    chk("rst_sel1", 8'(sel1), 8'(2'b11));
    cin = 4'd12; vld = 1'b1;
    go_to(2);
    vld = 1'b0;
    chk("p_sel1_first", 8'(sel1), 8'(2'b10));
    chk("p_seg1_first", seg1, 8'hC0);
    go_to(8);
    chk("p_sel1_next", 8'(sel1), 8'(2'b10));
    chk("p_seg1_next", seg1, 8'hA4);
    for (int i = 0; i < 10; i++) begin
      go_to(11 + i);
      chk("two_sel", 8'(sel0), 8'(two_sel[i]));
      chk("two_seg", seg0, two_seg[i]);
    end
    // wrap: 14, 15, 0, then equal and increasing values
    cin = 4'd14; vld = 1'b1;
    go_to(21); chk("wrap_14", 8'(wrap0), 8'd0);
    cin = 4'd15;
    go_to(22); chk("wrap_15", 8'(wrap0), 8'd0);
    cin = 4'd0;
    go_to(23); chk("wrap_0", 8'(wrap0), 8'd1);
    go_to(24); chk("wrap_eq", 8'(wrap0), 8'd0);
    cin = 4'd3;
    go_to(25); chk("wrap_inc", 8'(wrap0), 8'd0);
    vld = 1'b0;
    go_to(26); chk("wrap_idle", 8'(wrap0), 8'd0);
    // frame stability
    go_to(34); chk("stab_b0", seg0, 8'hB0);
    go_to(37);
    cin = 4'd7; vld = 1'b1;
    go_to(38);
    vld = 1'b0;
    chk("stab_dig1_sel", 8'(sel0), 8'(2'b01));
    chk("stab_dig1_seg", seg0, 8'hFF);
    go_to(41); chk("stab_f8", seg0, 8'hF8);
    // valid on the load edge: old value shown, new one next frame
    go_to(50);
    cin = 4'd9; vld = 1'b1;
    go_to(51);
    vld = 1'b0;
    chk("load_old", seg0, 8'hF8);
    go_to(61); chk("load_new", seg0, 8'h90);
    // reset mid-digit
    go_to(62);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", seg0, 8'hFF);
    chk("mid_rst_sel", 8'(sel0), 8'(2'b11));
    chk("mid_rst_wrap", 8'(wrap0), 8'd0);
    chk("mid_rst_sel1", 8'(sel1), 8'(2'b11));
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    cyc = 0;
    go_to(1);
    chk("post_rst_seg", seg0, 8'hC0);
    chk("post_rst_sel", 8'(sel0), 8'(2'b10));
    for (int i = 0; i < 4; i++) begin
      cin = vals[i]; vld = 1'b1;
      go_to(cyc + 1);
      vld = 1'b0;
      go_to(cyc + 11);
    end
    go_to(cyc + 20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
